lsu_mem_ctrl: RTL
=================

Name: lsu_mem_ctrl

Overview:
Memory-stage load/store controller between the EX/MEM pipeline register and the data-memory bus. Turns the M-stage access (address, funct3M, store data) into an aligned word request with byte enables, stalls the pipeline until the bus completes, and registers the lane-aligned read word. The aligned word is presented on ReadData so the downstream load-select stage can extract bits [7:0]/[15:0]/[31:0] directly. Misaligned and timed-out accesses are flagged instead of issued or completed.

Parameters:
TIMEOUT, 16, max cycles spent in REQ plus WAIT_R before aborting with BusErrM
ADDR_W, 32, address width

Ports:
clk  input  1  pipeline clock
rst_n  input  1  synchronous active-low reset
MemReadM  input  1  M-stage load
MemWriteM  input  1  M-stage store
funct3M  input  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
ALUResultM  input  ADDR_W  byte address
WriteDataM  input  32  store data, right-justified
StallM  output  1  hold IF..M stages
MisalignM  output  1  one-cycle misaligned-access flag
BusErrM  output  1  one-cycle timeout flag
ReadData  output  32  registered read word shifted right by 8*addr[1:0]
mem_req  output  1  bus request, registered
mem_we  output  1  1 store, 0 load
mem_addr  output  ADDR_W  word address {addr[ADDR_W-1:2],2'b00}
mem_be  output  4  byte enables
mem_wdata  output  32  lane-replicated store data
mem_gnt  input  1  request accepted this cycle
mem_rvalid  input  1  mem_rdata valid this cycle
mem_rdata  input  32  read word

Behaviour:
- Reset (rst_n=0 at clk edge): state IDLE; mem_req, mem_we, mem_addr, mem_be, mem_wdata, ReadData, timeout counter = 0; MisalignM, BusErrM = 0. Reset mid-transaction abandons it; mem_req low after that edge.
- off = ALUResultM[1:0]. Size from funct3M[1:0]: 00 byte, 01 half, 10 word; funct3M=011/11x treated as word.
- Byte enables: byte 4'b0001<<off; half 4'b0011<<off; word 4'b1111. Loads drive the same be.
- mem_wdata: byte {4{WriteDataM[7:0]}}; half {2{WriteDataM[15:0]}}; word WriteDataM.
- Misaligned: half with off[0]=1, word with off!=0. In IDLE: no request, StallM=0, MisalignM=1 for that cycle only (combinational on M inputs), ReadData unchanged.
- access = (MemReadM|MemWriteM) & aligned. MemReadM and MemWriteM both 1: store wins.
- FSM:
  IDLE: access -> latch addr/be/wdata/we/off, mem_req<=1, go REQ. StallM=access.
  REQ: mem_req, addr, be, wdata, we stable; StallM=1. mem_gnt: mem_req<=0; store -> DONE, load -> WAIT_R.
  WAIT_R: StallM=1. mem_rvalid: ReadData<=mem_rdata>>(8*off_latched), go DONE. mem_rvalid ignored in every other state.
  DONE: StallM=0 (pipeline advances); next state IDLE unconditionally (no re-issue of the same instruction).
- Timeout counter: cleared on IDLE->REQ, increments each cycle in REQ/WAIT_R. At TIMEOUT-1 with no completing gnt/rvalid: mem_req<=0, ReadData<=0, BusErrM=1 for the DONE cycle, go DONE. Completion on the same cycle as the limit wins (no error).
- ReadData holds its value until the next load capture, timeout or reset; stores never change it.
- Min latencies: store 2 cycles stalled (IDLE, REQ with gnt), load 3 (IDLE, REQ, WAIT_R) then DONE.

Test Plan:
- Reset: drive rst_n=0 during WAIT_R -> next edge state IDLE, mem_req=0, ReadData=0, StallM=0.
- SB addr 0x1003, WriteDataM=0x000000A5, gnt in first REQ cycle -> mem_addr=0x1000, mem_be=4'b1000, mem_wdata=0xA5A5A5A5, mem_we=1, StallM high 2 cycles, low in DONE.
- LH addr 0x2002, gnt after 2 cycles, rvalid 1 cycle later with 0xBEEF1234 -> mem_be=4'b1100, ReadData=0x0000BEEF, held through subsequent store.
- LW addr 0x3001 -> no mem_req, MisalignM=1 one cycle, StallM=0; SH addr 0x3003 -> same.
- LW addr 0x4000, gnt never asserted, TIMEOUT=16 -> mem_req drops after 16 stalled cycles, BusErrM=1 one cycle, ReadData=0.
- MemReadM=MemWriteM=1, funct3M=010 addr 0x5000 -> mem_we=1, mem_be=4'hF, completes as store, ReadData unchanged.

Source files
------------

// File: rtl/lsu_mem_ctrl.sv
// Memory-stage load/store controller.
// Converts the M-stage access into an aligned word request with byte enables.
// Holds the pipeline until the bus finishes, then registers the read word
// shifted down to lane 0. Misaligned accesses are flagged and never issued.
// Requests that run out of time are aborted and flagged on BusErrM.
module lsu_mem_ctrl #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned ADDR_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              MemReadM,
    input  logic              MemWriteM,
    input  logic [2:0]        funct3M,
    input  logic [ADDR_W-1:0] ALUResultM,
    input  logic [31:0]       WriteDataM,
    output logic              StallM,
    output logic              MisalignM,
    output logic              BusErrM,
    output logic [31:0]       ReadData,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata
);

    localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        WAIT_R = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       off_q;

    logic [1:0]  off;
    logic [3:0]  be_c;
    logic [31:0] wdata_c;
    logic        misaligned_c;
    logic        req_c;
    logic        access_c;
    logic        limit_c;
    logic        unused_sign;

    // Signedness only matters to the downstream load-select stage.
    assign unused_sign = funct3M[2];

    assign off = ALUResultM[1:0];

    // Size decode: byte enables, lane-replicated store data, alignment.
    always_comb begin
        be_c         = 4'b1111;
        wdata_c      = WriteDataM;
        misaligned_c = 1'b0;
        case (funct3M[1:0])
            2'b00: begin
                be_c    = 4'b0001 << off;
                wdata_c = {4{WriteDataM[7:0]}};
            end
            2'b01: begin
                be_c         = 4'b0011 << off;
                wdata_c      = {2{WriteDataM[15:0]}};
                misaligned_c = off[0];
            end
            default: begin
                misaligned_c = (off != 2'b00);
            end
        endcase
    end

    assign req_c    = MemReadM | MemWriteM;
    assign access_c = req_c & ~misaligned_c;
    assign limit_c  = (cnt >= CNT_W'(TIMEOUT - 1));

    // Stall while a request is being set up or is outstanding; release in DONE.
    always_comb begin
        StallM = 1'b0;
        case (state)
            IDLE:    StallM = access_c;
            REQ:     StallM = 1'b1;
            WAIT_R:  StallM = 1'b1;
            default: StallM = 1'b0;
        endcase
    end

    // Misalignment is reported only while idle, from the live M-stage inputs.
    assign MisalignM = (state == IDLE) & req_c & misaligned_c;

    // Access FSM with registered bus signals, read capture and timeout.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            off_q     <= 2'b00;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= 4'b0000;
            mem_wdata <= 32'h0;
            ReadData  <= 32'h0;
            BusErrM   <= 1'b0;
        end else begin
            BusErrM <= 1'b0;
            case (state)
                IDLE: begin
                    if (access_c) begin
                        mem_req   <= 1'b1;
                        mem_we    <= MemWriteM;
                        mem_addr  <= {ALUResultM[ADDR_W-1:2], 2'b00};
                        mem_be    <= be_c;
                        mem_wdata <= wdata_c;
                        off_q     <= off;
                        cnt       <= '0;
                        state     <= REQ;
                    end
                end
                REQ: begin
                    cnt <= cnt + CNT_W'(1);
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        state   <= mem_we ? DONE : WAIT_R;
                    end else if (limit_c) begin
                        mem_req  <= 1'b0;
                        ReadData <= 32'h0;
                        BusErrM  <= 1'b1;
                        state    <= DONE;
                    end
                end
                WAIT_R: begin
                    cnt <= cnt + CNT_W'(1);
                    if (mem_rvalid) begin
                        ReadData <= mem_rdata >> {off_q, 3'b000};
                        state    <= DONE;
                    end else if (limit_c) begin
                        ReadData <= 32'h0;
                        BusErrM  <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
